// File: rtl/dpram_port_arbiter_if.sv
// Requester-side bundle of the shared RAM port arbiter: packed per-requester
// request/address/data lanes and the one-hot ack/rvalid returns.
interface dpram_port_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ-1:0]            wren_in;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_in;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_in;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;

  modport master (output req, lock, wren_in, addr_in, wdata_in,
                  input  ack, rvalid, rdata);
  modport slave  (input  req, lock, wren_in, addr_in, wdata_in,
                  output ack, rvalid, rdata);
endinterface

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one port of a dual-port RAM, with bounded burst
// locking and 1-cycle read-return steering. DPRAM_ARB_PRIO0_EN gives requester 0 absolute priority.
module dpram_port_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  dpram_port_arbiter_if.slave   bus,
  output logic                  ram_enable,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] MAXB = 4'(MAX_BURST);

  logic [IW-1:0]      last;
  logic               owner_valid;
  logic [3:0]         burst_cnt;
  logic [NUM_REQ-1:0] rd_tag;

  logic               granted, locked_hit, preempt;
  logic [IW-1:0]      gidx;
  logic [IW:0]        rr_sum;
  logic [NUM_REQ-1:0] ack_c;

  always_comb begin
    granted    = 1'b0;
    locked_hit = 1'b0;
    preempt    = 1'b0;
    gidx       = last;
    rr_sum     = '0;
    if (owner_valid && bus.req[last] && burst_cnt < MAXB) begin
      granted    = 1'b1;
      locked_hit = 1'b1;
    end else begin
      // scan from last+1 with wrap; first asserted request wins
      for (int k = 1; k <= NUM_REQ; k++) begin
        rr_sum = {1'b0, last} + (IW+1)'(k);
        if (rr_sum >= (IW+1)'(NUM_REQ)) rr_sum = rr_sum - (IW+1)'(NUM_REQ);
        if (!granted && bus.req[rr_sum[IW-1:0]]) begin
          granted = 1'b1;
          gidx    = rr_sum[IW-1:0];
        end
      end
    end
`ifdef DPRAM_ARB_PRIO0_EN
    if (bus.req[0] && !(locked_hit && last == '0)) begin
      preempt    = 1'b1;
      granted    = 1'b1;
      locked_hit = 1'b0;
      gidx       = '0;
    end
`endif
    if (reset) granted = 1'b0;
  end

  always_comb begin
    ack_c       = '0;
    ram_enable  = 1'b0;
    ram_wren    = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    if (granted) begin
      ack_c[gidx] = 1'b1;
      ram_enable  = 1'b1;
      ram_wren    = bus.wren_in[gidx];
      ram_address = bus.addr_in[gidx*ADDR_WIDTH +: ADDR_WIDTH];
      ram_data    = bus.wdata_in[gidx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last        <= IW'(NUM_REQ-1);
      owner_valid <= 1'b0;
      burst_cnt   <= '0;
      rd_tag      <= '0;
    end else begin
      rd_tag <= ack_c & ~bus.wren_in;
      if (granted) begin
        last <= gidx;
        // only a continued locked burst counts up; an RR re-grant restarts it
        if (locked_hit) burst_cnt <= (burst_cnt >= MAXB) ? MAXB : burst_cnt + 4'd1;
        else            burst_cnt <= 4'd1;
        owner_valid <= preempt ? 1'b0 : bus.lock[gidx];
      end else begin
        owner_valid <= 1'b0;
        burst_cnt   <= '0;
      end
    end
  end

  assign bus.ack    = ack_c;
  assign bus.rvalid = rd_tag;
  assign bus.rdata  = ram_q;
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter: RR order, burst locking, write/read
// return, async reset mid-access and idle RAM drive, against a 1-cycle RAM model.
module tb_dpram_port_arbiter;
  logic clock, reset;
  logic        ram_enable, ram_wren;
  logic [14:0] ram_address;
  logic [7:0]  ram_data, ram_q;
  int n_cmp = 0, n_bad = 0;

  dpram_port_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(15), .DATA_WIDTH(8)) bif ();

  dpram_port_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(15), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clock(clock), .reset(reset), .bus(bif),
    .ram_enable(ram_enable), .ram_wren(ram_wren), .ram_address(ram_address),
    .ram_data(ram_data), .ram_q(ram_q));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] pre(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]};
  endfunction

  // RAM model: preloaded pattern until written, registered read
  bit [7:0] wmem [32768];
  bit       wflag [32768];
  always @(posedge clock) begin
    if (ram_enable) begin
      if (ram_wren) begin wmem[ram_address] <= ram_data; wflag[ram_address] <= 1'b1; end
      else ram_q <= wflag[ram_address] ? wmem[ram_address] : pre(ram_address);
    end
  end

  task automatic idle_inputs();
    bif.req = '0; bif.lock = '0; bif.wren_in = '0; bif.addr_in = '0; bif.wdata_in = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle_inputs();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_inputs(); bif.req = 3'b111;
    #3;
    n_cmp++; if (bif.ack !== 3'b000) begin n_bad++; $display("FAIL reset_ack got %b want 000", bif.ack); end
    n_cmp++; if (bif.rvalid !== 3'b000) begin n_bad++; $display("FAIL reset_rvalid got %b want 000", bif.rvalid); end
    n_cmp++; if (ram_enable !== 1'b0) begin n_bad++; $display("FAIL reset_en got %b want 0", ram_enable); end
    step(); step();
    reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (bif.ack !== 3'b001) begin n_bad++; $display("FAIL reset_first_grant got %b want 001", bif.ack); end
    step();
  endtask

  task automatic test_rr_reads();
    logic [2:0]  ea [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [14:0] ed [4] = '{15'h0100, 15'h0201, 15'h0302, 15'h0100};
    do_reset();
    bif.req = 3'b111; bif.addr_in = {15'h0302, 15'h0201, 15'h0100};
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (c < 4) begin
        n_cmp++; if (bif.ack !== ea[c]) begin n_bad++; $display("FAIL rr_ack c=%0d got %b want %b", c, bif.ack, ea[c]); end
        n_cmp++; if (ram_address !== ed[c]) begin n_bad++; $display("FAIL rr_addr c=%0d got %h want %h", c, ram_address, ed[c]); end
      end
      if (c > 0) begin
        n_cmp++; if (bif.rvalid !== ea[c-1]) begin n_bad++; $display("FAIL rr_rvalid c=%0d got %b want %b", c, bif.rvalid, ea[c-1]); end
        n_cmp++; if (bif.rdata !== pre(ed[c-1])) begin n_bad++; $display("FAIL rr_rdata c=%0d got %h want %h", c, bif.rdata, pre(ed[c-1])); end
      end
      step();
      if (c == 3) bif.req = 3'b000;
    end
  endtask

  task automatic test_lock_burst();
    logic [2:0] ea [5] = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b001};
    do_reset();
    bif.req = 3'b010; bif.lock = 3'b010;
    @(negedge clock);
    n_cmp++; if (bif.ack !== 3'b010) begin n_bad++; $display("FAIL lock_start got %b want 010", bif.ack); end
    step();
    bif.req = 3'b111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      n_cmp++; if (bif.ack !== ea[c]) begin n_bad++; $display("FAIL lock_seq c=%0d got %b want %b", c, bif.ack, ea[c]); end
      step();
    end
    // sole locked requester keeps winning across burst expiry
    do_reset();
    bif.req = 3'b010; bif.lock = 3'b010;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      n_cmp++; if (bif.ack !== 3'b010) begin n_bad++; $display("FAIL lock_solo c=%0d got %b want 010", c, bif.ack); end
      step();
    end
    // lock without req, and lock released on a grant
    do_reset();
    bif.req = 3'b001; bif.lock = 3'b110;
    @(negedge clock);
    n_cmp++; if (bif.ack !== 3'b001) begin n_bad++; $display("FAIL lock_noreq got %b want 001", bif.ack); end
    step();
    bif.req = 3'b111;
    @(negedge clock);
    n_cmp++; if (bif.ack !== 3'b010) begin n_bad++; $display("FAIL lock_release got %b want 010", bif.ack); end
    step();
    idle_inputs();
  endtask

  task automatic test_write_read();
    do_reset();
    bif.req = 3'b100; bif.wren_in = 3'b100;
    bif.addr_in = {15'h0123, 15'h0000, 15'h0000}; bif.wdata_in = {8'hA5, 8'h00, 8'h00};
    @(negedge clock);
    n_cmp++; if (bif.ack !== 3'b100) begin n_bad++; $display("FAIL wr_ack got %b want 100", bif.ack); end
    n_cmp++; if ({ram_enable, ram_wren} !== 2'b11) begin n_bad++; $display("FAIL wr_en got %b want 11", {ram_enable, ram_wren}); end
    n_cmp++; if ({ram_address, ram_data} !== {15'h0123, 8'hA5}) begin n_bad++; $display("FAIL wr_bus got %h/%h want 0123/a5", ram_address, ram_data); end
    step();
    bif.req = 3'b001; bif.wren_in = 3'b000; bif.addr_in = {15'h0000, 15'h0000, 15'h0123};
    @(negedge clock);
    n_cmp++; if (bif.ack !== 3'b001) begin n_bad++; $display("FAIL rd_ack got %b want 001", bif.ack); end
    n_cmp++; if (bif.rvalid !== 3'b000) begin n_bad++; $display("FAIL wr_no_rvalid got %b want 000", bif.rvalid); end
    step();
    bif.req = 3'b000;
    @(negedge clock);
    n_cmp++; if (bif.rvalid !== 3'b001) begin n_bad++; $display("FAIL rd_rvalid got %b want 001", bif.rvalid); end
    n_cmp++; if (bif.rdata !== 8'hA5) begin n_bad++; $display("FAIL rd_rdata got %h want a5", bif.rdata); end
    step();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bif.req = 3'b010; bif.addr_in = {15'h0000, 15'h0055, 15'h0000};
    @(negedge clock);
    n_cmp++; if (bif.ack !== 3'b010) begin n_bad++; $display("FAIL mid_ack got %b want 010", bif.ack); end
    #1 reset = 1'b1; bif.req = 3'b111;
    #1;
    n_cmp++; if ({bif.ack, ram_enable} !== 4'b0000) begin n_bad++; $display("FAIL mid_async got %b want 0000", {bif.ack, ram_enable}); end
    step();
    n_cmp++; if (bif.rvalid !== 3'b000) begin n_bad++; $display("FAIL mid_tag_drop got %b want 000", bif.rvalid); end
    reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (bif.ack !== 3'b001) begin n_bad++; $display("FAIL mid_regrant got %b want 001", bif.ack); end
    step();
    idle_inputs();
  endtask

  task automatic test_idle();
    do_reset();
    bif.lock = 3'b111; bif.wren_in = 3'b111;
    bif.addr_in = {15'h7FFF, 15'h1234, 15'h0F0F}; bif.wdata_in = {8'hFF, 8'h5A, 8'hC3};
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_cmp++;
      if ({ram_enable, ram_wren, ram_address, ram_data, bif.ack, bif.rvalid} !== '0) begin
        n_bad++;
        $display("FAIL idle c=%0d got en=%b wr=%b a=%h d=%h ack=%b rv=%b want all 0",
                 c, ram_enable, ram_wren, ram_address, ram_data, bif.ack, bif.rvalid);
      end
      step();
    end
    idle_inputs();
  endtask

`ifdef DPRAM_ARB_PRIO0_EN
  task automatic test_prio0();
    do_reset();
    bif.req = 3'b100; bif.lock = 3'b100;
    step(); step();
    bif.req = 3'b101;
    @(negedge clock);
    n_cmp++; if (bif.ack !== 3'b001) begin n_bad++; $display("FAIL prio0_preempt got %b want 001", bif.ack); end
    step();
    idle_inputs();
  endtask
`endif

  initial begin
    reset = 1'b1; idle_inputs();
    test_reset();
    test_rr_reads();
    test_lock_burst();
    test_write_read();
    test_reset_mid();
    test_idle();
`ifdef DPRAM_ARB_PRIO0_EN
    test_prio0();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
